// File: rtl/led_step_clock_divider_pkg.sv
// rtl/led_step_clock_divider_pkg.sv - shared constants and speed command type for the LED step clock
package led_step_pkg;

  localparam int unsigned CNT_W              = 32;
  localparam int unsigned DEFAULT_HALF_50MHZ = 25_000_000;
  localparam int unsigned STEP_50MHZ         = 1_000_000;
  localparam int unsigned MIN_HALF           = 2;
  localparam int unsigned MAX_HALF           = 200_000_000;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_UP,
    CMD_DOWN,
    CMD_DEFAULT
  } speed_cmd_t;

  // Restore-default wins outright; opposing up/down requests cancel.
  function automatic speed_cmd_t decode_speed(input logic up_evt,
                                              input logic down_evt,
                                              input logic default_evt);
    if (default_evt)
      return CMD_DEFAULT;
    else if (up_evt && down_evt)
      return CMD_NONE;
    else if (up_evt)
      return CMD_UP;
    else if (down_evt)
      return CMD_DOWN;
    else
      return CMD_NONE;
  endfunction

endpackage

// File: rtl/led_step_clock_divider_if.sv
// rtl/led_step_clock_divider_if.sv - run/button controls and divided-clock outputs of the step clock
interface led_step_clock_divider_if #(
  parameter int unsigned CNT_W = led_step_pkg::CNT_W
);

  logic             run;
  logic             speed_up;
  logic             speed_down;
  logic             speed_reset;
  logic             div_clk;
  logic             tick;
  logic [CNT_W-1:0] half_period;

  modport master (
    output run, speed_up, speed_down, speed_reset,
    input  div_clk, tick, half_period
  );

  modport slave (
    input  run, speed_up, speed_down, speed_reset,
    output div_clk, tick, half_period
  );

endinterface

// File: rtl/led_step_clock_divider_button_edge_sync.sv
// rtl/led_step_clock_divider_button_edge_sync.sv - two-flop synchronizer with one-cycle rising-edge pulse
module button_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign pulse = sync2 & ~prev;

endmodule

// File: rtl/led_step_clock_divider.sv
// rtl/led_step_clock_divider.sv - run-time adjustable 50% duty step clock with rising-edge tick
module led_step_clock_divider #(
  parameter int unsigned CNT_W        = led_step_pkg::CNT_W,
  parameter int unsigned DEFAULT_HALF = led_step_pkg::DEFAULT_HALF_50MHZ,
  parameter int unsigned STEP         = led_step_pkg::STEP_50MHZ,
  parameter int unsigned MIN_HALF     = led_step_pkg::MIN_HALF,
  parameter int unsigned MAX_HALF     = led_step_pkg::MAX_HALF
) (
  input  logic                    clk,
  input  logic                    reset,
  led_step_clock_divider_if.slave bus
);

  import led_step_pkg::*;

  if (!(MIN_HALF >= 2 && MIN_HALF <= DEFAULT_HALF && DEFAULT_HALF <= MAX_HALF &&
        64'(MAX_HALF) < (64'd1 << CNT_W) && STEP >= 1)) begin : g_param_check
    $error("led_step_clock_divider: illegal half-period parameters");
  end

  localparam logic [CNT_W-1:0] DEF_L  = CNT_W'(DEFAULT_HALF);
  localparam logic [CNT_W-1:0] STEP_L = CNT_W'(STEP);
  localparam logic [CNT_W-1:0] MIN_L  = CNT_W'(MIN_HALF);
  localparam logic [CNT_W-1:0] MAX_L  = CNT_W'(MAX_HALF);
  localparam logic [CNT_W-1:0] ONE_L  = CNT_W'(1);

  logic             up_evt;
  logic             down_evt;
  logic             default_evt;
  speed_cmd_t       cmd;
  logic [CNT_W-1:0] half_q;
  logic [CNT_W-1:0] count_q;
  logic             div_q;
  logic             tick_q;
  logic             wrap;

  button_edge_sync u_up (
    .clk   (clk),
    .reset (reset),
    .in    (bus.speed_up),
    .pulse (up_evt)
  );

  button_edge_sync u_down (
    .clk   (clk),
    .reset (reset),
    .in    (bus.speed_down),
    .pulse (down_evt)
  );

  button_edge_sync u_default (
    .clk   (clk),
    .reset (reset),
    .in    (bus.speed_reset),
    .pulse (default_evt)
  );

  assign cmd = decode_speed(up_evt, down_evt, default_evt);

  // Clamp tests use distance to the limit so neither direction can wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      half_q <= DEF_L;
    end else begin
      case (cmd)
        CMD_DEFAULT: half_q <= DEF_L;
        CMD_UP:      half_q <= ((half_q - MIN_L) >= STEP_L) ? (half_q - STEP_L) : MIN_L;
        CMD_DOWN:    half_q <= ((MAX_L - half_q) >= STEP_L) ? (half_q + STEP_L) : MAX_L;
        default:     half_q <= half_q;
      endcase
    end
  end

  // >= rather than == so a shrunken half-period wraps immediately instead of running to 2^CNT_W.
  assign wrap = (count_q >= (half_q - ONE_L));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      div_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (bus.run) begin
        if (wrap) begin
          count_q <= '0;
          div_q   <= ~div_q;
          tick_q  <= ~div_q;
        end else begin
          count_q <= count_q + ONE_L;
        end
      end
    end
  end

  assign bus.div_clk     = div_q;
  assign bus.tick        = tick_q;
  assign bus.half_period = half_q;

endmodule

// File: tb/tb_led_step_clock_divider.sv
// tb/tb_led_step_clock_divider.sv - directed self-checking bench for the LED step clock divider
module tb_led_step_clock_divider;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  led_step_clock_divider_if #(.CNT_W(8)) bus();

  led_step_clock_divider #(
    .CNT_W        (8),
    .DEFAULT_HALF (4),
    .STEP         (2),
    .MIN_HALF     (2),
    .MAX_HALF     (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // mask = {speed_reset, speed_down, speed_up}
  task automatic press(input logic [2:0] mask);
    {bus.speed_reset, bus.speed_down, bus.speed_up} = mask;
    repeat (3) @(negedge clk);
    {bus.speed_reset, bus.speed_down, bus.speed_up} = 3'b000;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    bus.run = 1'b0;
    {bus.speed_reset, bus.speed_down, bus.speed_up} = 3'b000;
    @(negedge clk);
    check("rst_div", 32'(bus.div_clk), 0);
    check("rst_tick", 32'(bus.tick), 0);
    check("rst_half", 32'(bus.half_period), 4);

    // 1: default half-period 4 -> rises at edges 4, 12, 20; falls at 8, 16
    do_reset();
    bus.run = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      check("t1_div", 32'(bus.div_clk), 32'((k / 4) % 2));
      check("t1_tick", 32'(bus.tick), 32'(k % 8 == 4));
    end
    check("t1_half", 32'(bus.half_period), 4);

    // 2: speed_up 4->2 lands on the third edge, then clamps at 2
    bus.run = 1'b0;
    do_reset();
    bus.speed_up = 1'b1;
    repeat (2) @(negedge clk);
    check("t2_half_pre", 32'(bus.half_period), 4);
    @(negedge clk);
    check("t2_half_post", 32'(bus.half_period), 2);
    bus.speed_up = 1'b0;
    repeat (3) @(negedge clk);
    press(3'b001);
    check("t2_half_clamp", 32'(bus.half_period), 2);
    bus.run = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("t2_div", 32'(bus.div_clk), 32'((k / 2) % 2));
      check("t2_tick", 32'(bus.tick), 32'(k % 4 == 2));
    end

    // 3: speed_down 6, 8, 10, 10 then restore default
    bus.run = 1'b0;
    do_reset();
    press(3'b010);
    check("t3_half_6", 32'(bus.half_period), 6);
    press(3'b010);
    check("t3_half_8", 32'(bus.half_period), 8);
    press(3'b010);
    check("t3_half_10", 32'(bus.half_period), 10);
    press(3'b010);
    check("t3_half_clamp", 32'(bus.half_period), 10);
    press(3'b100);
    check("t3_half_default", 32'(bus.half_period), 4);

    // 4: half 10, count parked at 7, shrink to 6 -> toggle on the very next edge
    do_reset();
    press(3'b010);
    press(3'b010);
    press(3'b010);
    check("t4_half_10", 32'(bus.half_period), 10);
    bus.run = 1'b1;
    repeat (7) @(negedge clk);
    bus.run = 1'b0;
    check("t4_div_pre", 32'(bus.div_clk), 0);
    press(3'b001);
    press(3'b001);
    check("t4_half_6", 32'(bus.half_period), 6);
    bus.run = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      check("t4_div", 32'(bus.div_clk), (k < 7 || k >= 13) ? 32'd1 : 32'd0);
      check("t4_tick", 32'(bus.tick), 32'(k == 1 || k == 13));
    end

    // 5: simultaneous presses and a long hold
    bus.run = 1'b0;
    do_reset();
    press(3'b011);
    check("t5_up_down", 32'(bus.half_period), 4);
    bus.speed_down = 1'b1;
    repeat (50) @(negedge clk);
    check("t5_hold", 32'(bus.half_period), 6);
    bus.speed_down = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_hold_release", 32'(bus.half_period), 6);
    press(3'b111);
    check("t5_all_three", 32'(bus.half_period), 4);

    // 6: pause freezes count and div_clk; async reset mid-period
    do_reset();
    bus.run = 1'b1;
    repeat (6) @(negedge clk);
    check("t6_div_run", 32'(bus.div_clk), 1);
    bus.run = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("t6_tick_paused", 32'(bus.tick), 0);
    end
    check("t6_div_paused", 32'(bus.div_clk), 1);
    bus.run = 1'b1;
    @(negedge clk);
    check("t6_div_resume1", 32'(bus.div_clk), 1);
    @(negedge clk);
    check("t6_div_resume2", 32'(bus.div_clk), 0);
    press(3'b010);
    check("t6_half_6", 32'(bus.half_period), 6);
    begin
      int budget;
      budget = 30;
      while (bus.div_clk !== 1'b1 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      check("t6_div_high_wait", 32'(bus.div_clk), 1);
    end
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_div", 32'(bus.div_clk), 0);
    check("t6_async_tick", 32'(bus.tick), 0);
    check("t6_async_half", 32'(bus.half_period), 4);
    @(negedge clk);
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/led_step_clock_divider.md
Name: led_step_clock_divider

Overview:
Generates the slow step clock that drives the bouncing-LED FSM, derived from the 50 MHz system clock. It produces a 50%-duty divided clock `div_clk` and a one-cycle `tick` aligned with each `div_clk` rising edge. The step rate is adjustable at run time from three push-button inputs: faster, slower and default. The LED FSM sits directly downstream and consumes `div_clk`, or `tick` as a step enable.

Parameters:
CNT_W, 32, width of the half-period counter and register.
DEFAULT_HALF, 25_000_000, half-period in clk cycles after reset or speed_reset; 0.5 s at 50 MHz.
STEP, 1_000_000, half-period increment/decrement per speed event.
MIN_HALF, 2, lowest allowed half-period.
MAX_HALF, 200_000_000, highest allowed half-period.

Ports:
clk  input  1  system clock, 50 MHz.
reset  input  1  asynchronous, active-high reset.
run  input  1  synchronous enable; when low, counting pauses.
speed_up  input  1  asynchronous button level; rising edge shortens the period.
speed_down  input  1  asynchronous button level; rising edge lengthens the period.
speed_reset  input  1  asynchronous button level; rising edge restores DEFAULT_HALF.
div_clk  output  1  divided clock, 50% duty; full period = 2*half_period cycles.
tick  output  1  one-clk pulse on each 0->1 transition of div_clk.
half_period  output  CNT_W  current half-period register value.

Behaviour:
- Reset values (asynchronous): count=0, div_clk=0, tick=0, half_period=DEFAULT_HALF, all synchronizer and edge flops 0.
- Button conditioning, per button: 2-FF synchronizer, then a registered previous value; `evt` = sync & ~prev.
  - `evt` is high for exactly one clk per rising edge.
  - half_period updates on the 3rd clk edge after the input rises.
  - Holding a button level high produces no repeats.
- half_period update priority, evaluated each clk when any `evt` is high:
  1. speed_reset evt: half_period <= DEFAULT_HALF; up/down in the same cycle are ignored.
  2. up evt and down evt together: no change.
  3. up evt only: half_period <= max(half_period-STEP, MIN_HALF). The compare is done before subtracting, so there is no underflow wrap.
  4. down evt only: half_period <= min(half_period+STEP, MAX_HALF). The compare uses headroom, so there is no overflow wrap.
- Speed events are accepted regardless of run.
- Counter:
  - When run=1: if count >= half_period-1, then count <= 0 and div_clk <= ~div_clk; otherwise count <= count+1.
  - The >= compare guarantees wrap when half_period shrinks below the current count. The next toggle then comes one cycle later, with no 2^CNT_W runaway.
  - When run=0: count, div_clk and half_period-dependent timing hold; tick=0.
- tick: registered. tick <= 1 in the cycle div_clk is registered 0->1, else 0. So tick is high for the first clk cycle in which div_clk reads 1.
- Steady state: div_clk high for half_period cycles, low for half_period cycles.
  - First rising edge after reset occurs at clk edge DEFAULT_HALF.
  - A new half_period takes effect at the next compare; no glitch or partial reload.
- Reset mid-operation immediately forces all reset values, including reverting half_period to DEFAULT_HALF.
- Parameter legality, checked by elaboration assertion: 2 <= MIN_HALF <= DEFAULT_HALF <= MAX_HALF < 2^CNT_W, and STEP >= 1.

Decomposition:
- Package led_step_pkg holds: DEFAULT_HALF_50MHZ, STEP_50MHZ, MIN_HALF, MAX_HALF localparams; CNT_W; and an enum speed_cmd_t {CMD_NONE, CMD_UP, CMD_DOWN, CMD_DEFAULT} used by the priority decoder.
- One sub-module, button_edge_sync: 2-FF synchronizer plus rising-edge pulse, with clk/reset/in/pulse ports. It is instantiated three times.
- Counter, toggle and tick logic stay in the top module.

Test Plan:
Use CNT_W=8, DEFAULT_HALF=4, STEP=2, MIN_HALF=2, MAX_HALF=10 unless noted.
1. Reset, run=1, no buttons -> div_clk rises at clk edges 4, 12, 20 and falls at 8, 16; tick high exactly the cycles div_clk first reads 1; half_period=4 throughout.
2. Pulse speed_up once -> half_period 4->2 three cycles after the rise; pulse again -> stays 2 (clamp); div_clk period becomes 4 cycles.
3. Pulse speed_down 4 times from 4 -> 6, 8, 10, 10 (clamp at MAX_HALF); then pulse speed_reset -> 4.
4. Set half_period=10, wait until count=7, then speed_up twice to 6 -> wrap on the next cycle via >= compare; subsequent half-periods are exactly 6; no wait of ~256 cycles.
5. Raise speed_up and speed_down in the same cycle -> no change; raise all three together -> half_period=DEFAULT_HALF. Hold a button high for 50 cycles -> only one event.
6. run=0 mid-period for 20 cycles -> div_clk and count frozen, tick never asserts. Assert reset mid-period -> div_clk=0, tick=0, half_period=4 immediately (asynchronously).
